// File: rtl/systolic_seq_pkg.sv
// Shared types for the systolic job sequencer.
// state_e is also decoded by the debug LEDs.
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    DRAIN = 2'd3
  } state_e;

endpackage

// File: rtl/systolic_seq_up_counter.sv
// Up counter with synchronous clear and enable.
// Ports: clk_i, reset_i, clear_i, en_i, count_o.
module up_counter #(
  parameter int width_p = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               clear_i,
  input  logic               en_i,
  output logic [width_p-1:0] count_o
);

  always_ff @(posedge clk_i) begin
    if (reset_i || clear_i)
      count_o <= '0;
    else if (en_i)
      count_o <= count_o + width_p'(1);
  end

endmodule

// File: rtl/systolic_seq.sv
// Job sequencer: operands into the array, one flush, results out.
// Ports: operand in (valid/data/ready), array side (sa_*), results out
// (valid/data/yumi), abort_i, busy_o, sticky watchdog error_o.
module systolic_seq
  import systolic_pkg::*;
#(
  parameter int width_p        = 8,
  parameter int array_width_p  = 2,
  parameter int array_height_p = 2,
  parameter int timeout_p      = 1024
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               abort_i,
  input  logic               valid_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,
  output logic               sa_valid_o,
  output logic [width_p-1:0] sa_data_o,
  input  logic               sa_ready_i,
  output logic               sa_flush_o,
  input  logic               sa_valid_i,
  input  logic [width_p-1:0] sa_data_i,
  output logic               sa_yumi_o,
  output logic               valid_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i,
  output logic               busy_o,
  output logic               error_o
);

  localparam int num_macs_p = array_width_p * array_height_p;
  localparam int ops_p      = 2 * num_macs_p;
  localparam int cnt_w      = $clog2(ops_p + 1);
  localparam int wd_w       = $clog2(timeout_p + 1);

  state_e state;

  logic [cnt_w-1:0] op_cnt;
  logic [cnt_w-1:0] res_cnt;
  logic [wd_w-1:0]  wd_cnt;

  logic in_load;
  logic in_drain;
  logic abort_act;
  logic accept;
  logic op_last;
  logic res_last;
  logic timeout;

  assign in_load  = (state == IDLE) || (state == LOAD);
  assign in_drain = (state == DRAIN);
  assign busy_o   = (state != IDLE);

  // abort only means something while a job is in flight
  assign abort_act = abort_i && busy_o;

  assign ready_o    = in_load && sa_ready_i && !abort_act;
  assign sa_valid_o = in_load && valid_i && !abort_act;
  assign sa_data_o  = in_load ? data_i : '0;
  assign accept     = valid_i && ready_o;

  assign valid_o   = in_drain && sa_valid_i && !abort_act;
  assign data_o    = in_drain ? sa_data_i : '0;
  assign sa_yumi_o = valid_o && yumi_i;

  assign op_last  = (op_cnt == cnt_w'(ops_p - 1));
  assign res_last = (res_cnt == cnt_w'(num_macs_p - 1));
  assign timeout  = in_drain && !abort_act &&
                    (wd_cnt == wd_w'(timeout_p - 1));

  assign sa_flush_o = (state == FLUSH) || abort_act || timeout;

  up_counter #(.width_p(cnt_w)) u_op (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (abort_act || (accept && op_last)),
    .en_i    (accept),
    .count_o (op_cnt)
  );

  up_counter #(.width_p(cnt_w)) u_res (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (abort_act || timeout || (sa_yumi_o && res_last)),
    .en_i    (sa_yumi_o),
    .count_o (res_cnt)
  );

  // watchdog measures the gap since the last taken result
  up_counter #(.width_p(wd_w)) u_wd (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (!in_drain || abort_act || timeout || sa_yumi_o),
    .en_i    (in_drain),
    .count_o (wd_cnt)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state   <= IDLE;
      error_o <= 1'b0;
    end else if (abort_act) begin
      state <= IDLE;
    end else if (timeout) begin
      state   <= IDLE;
      error_o <= 1'b1;
    end else begin
      if (accept)
        error_o <= 1'b0;
      unique case (state)
        IDLE:    if (accept) state <= LOAD;
        LOAD:    if (accept && op_last) state <= FLUSH;
        FLUSH:   state <= DRAIN;
        DRAIN:   if (sa_yumi_o && res_last) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_seq.sv
// Directed bench for systolic_seq (2x2 array, 16-cycle watchdog).
// Each task drives one scenario and checks its own outputs.
module tb_systolic_seq;

  logic       clk = 1'b0;
  logic       reset_i, abort_i, valid_i, sa_ready_i;
  logic       sa_valid_i, yumi_i;
  logic [7:0] data_i, sa_data_i;
  logic       ready_o, sa_valid_o, sa_flush_o, sa_yumi_o;
  logic       valid_o, busy_o, error_o;
  logic [7:0] sa_data_o, data_o;

  int total = 0;
  int bad   = 0;
  int flush_cnt = 0;

  always #5 clk = ~clk;

  always @(negedge clk)
    if (sa_flush_o === 1'b1) flush_cnt++;

  systolic_seq #(
    .width_p(8), .array_width_p(2),
    .array_height_p(2), .timeout_p(16)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .abort_i(abort_i),
    .valid_i(valid_i), .data_i(data_i), .ready_o(ready_o),
    .sa_valid_o(sa_valid_o), .sa_data_o(sa_data_o),
    .sa_ready_i(sa_ready_i), .sa_flush_o(sa_flush_o),
    .sa_valid_i(sa_valid_i), .sa_data_i(sa_data_i),
    .sa_yumi_o(sa_yumi_o), .valid_o(valid_o), .data_o(data_o),
    .yumi_i(yumi_i), .busy_o(busy_o), .error_o(error_o)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    reset_i = 1; abort_i = 0; valid_i = 0; data_i = 0;
    sa_ready_i = 1; sa_valid_i = 0; sa_data_i = 0; yumi_i = 0;
    step; step;
    reset_i = 0;
  endtask

  task automatic test_reset;
    apply_reset;
    #1;
    total++; if (busy_o !== 1'b0) begin bad++;
      $display("FAIL rst_busy got=%b exp=0", busy_o); end
    total++; if (error_o !== 1'b0) begin bad++;
      $display("FAIL rst_error got=%b exp=0", error_o); end
    total++; if (sa_flush_o !== 1'b0) begin bad++;
      $display("FAIL rst_flush got=%b exp=0", sa_flush_o); end
    total++; if (valid_o !== 1'b0) begin bad++;
      $display("FAIL rst_valid got=%b exp=0", valid_o); end
    total++; if (data_o !== 8'h00) begin bad++;
      $display("FAIL rst_data got=%h exp=00", data_o); end
    total++; if (ready_o !== 1'b1) begin bad++;
      $display("FAIL rst_ready got=%b exp=1", ready_o); end
  endtask

  // feeds n operands 1..n; sa_ready_i drops for stall_len cycles at acc==stall_at
  task automatic feed(input int n, input int stall_at, input int stall_len,
                      output int acc, output int cyc);
    int   stalled = 0;
    logic exp_rdy;
    acc = 0; cyc = 0;
    while (acc < n && cyc < 100) begin
      valid_i = 1; data_i = 8'(acc + 1);
      exp_rdy = !(acc == stall_at && stalled < stall_len);
      if (!exp_rdy) stalled++;
      sa_ready_i = exp_rdy;
      #1;
      total++; if (ready_o !== exp_rdy) begin bad++;
        $display("FAIL feed_ready op=%0d got=%b exp=%b", acc, ready_o, exp_rdy); end
      total++; if (sa_valid_o !== 1'b1 || sa_data_o !== 8'(acc + 1)) begin bad++;
        $display("FAIL feed_sa op=%0d got=%b/%h exp=1/%h",
                 acc, sa_valid_o, sa_data_o, 8'(acc + 1)); end
      total++; if (busy_o !== (acc > 0)) begin bad++;
        $display("FAIL feed_busy op=%0d got=%b exp=%b", acc, busy_o, acc > 0); end
      total++; if (sa_flush_o !== 1'b0) begin bad++;
        $display("FAIL feed_flush op=%0d got=%b exp=0", acc, sa_flush_o); end
      if (exp_rdy) acc++;
      step;
      cyc++;
    end
    valid_i = 0; sa_ready_i = 1;
  endtask

  task automatic check_flush;
    #1;
    total++; if (sa_flush_o !== 1'b1) begin bad++;
      $display("FAIL flush_pulse got=%b exp=1", sa_flush_o); end
    total++; if (ready_o !== 1'b0 || sa_valid_o !== 1'b0) begin bad++;
      $display("FAIL flush_hs got=%b/%b exp=0/0", ready_o, sa_valid_o); end
    total++; if (busy_o !== 1'b1) begin bad++;
      $display("FAIL flush_busy got=%b exp=1", busy_o); end
    step;
  endtask

  task automatic drain(input bit toggle);
    int   taken = 0;
    int   cyc = 0;
    logic exp_y;
    sa_valid_i = 1;
    while (taken < 4 && cyc < 50) begin
      sa_data_i = 8'h1A + 8'(taken);
      exp_y = toggle ? (cyc % 2 == 0) : 1'b1;
      yumi_i = exp_y;
      #1;
      total++; if (valid_o !== 1'b1 || data_o !== 8'h1A + 8'(taken)) begin bad++;
        $display("FAIL drain_out n=%0d got=%b/%h exp=1/%h",
                 taken, valid_o, data_o, 8'h1A + 8'(taken)); end
      total++; if (sa_yumi_o !== exp_y) begin bad++;
        $display("FAIL drain_yumi n=%0d got=%b exp=%b", taken, sa_yumi_o, exp_y); end
      total++; if (busy_o !== 1'b1 || sa_flush_o !== 1'b0) begin bad++;
        $display("FAIL drain_busy n=%0d got=%b/%b exp=1/0", taken, busy_o, sa_flush_o); end
      if (exp_y) taken++;
      step;
      cyc++;
    end
    yumi_i = 0; sa_valid_i = 0;
    #1;
    total++; if (cyc !== (toggle ? 7 : 4)) begin bad++;
      $display("FAIL drain_cycles got=%0d exp=%0d", cyc, toggle ? 7 : 4); end
    total++; if (busy_o !== 1'b0 || valid_o !== 1'b0) begin bad++;
      $display("FAIL drain_idle got=%b/%b exp=0/0", busy_o, valid_o); end
  endtask

  task automatic test_basic_job;
    int acc, cyc, f0;
    f0 = flush_cnt;
    feed(8, -1, 0, acc, cyc);
    total++; if (acc !== 8 || cyc !== 8) begin bad++;
      $display("FAIL basic_ops got=%0d/%0d exp=8/8", acc, cyc); end
    check_flush;
    drain(1'b0);
    total++; if (flush_cnt - f0 !== 1) begin bad++;
      $display("FAIL basic_flush_count got=%0d exp=1", flush_cnt - f0); end
  endtask

  task automatic test_drain_stall;
    int acc, cyc;
    feed(8, -1, 0, acc, cyc);
    check_flush;
    drain(1'b1);
  endtask

  task automatic test_backpressure;
    int acc, cyc;
    feed(8, 3, 3, acc, cyc);
    total++; if (acc !== 8 || cyc !== 11) begin bad++;
      $display("FAIL bp_ops got=%0d/%0d exp=8/11", acc, cyc); end
    check_flush;
    drain(1'b0);
  endtask

  task automatic test_abort;
    int acc, cyc;
    feed(5, -1, 0, acc, cyc);
    valid_i = 1; data_i = 8'h06; abort_i = 1;
    #1;
    total++; if (sa_flush_o !== 1'b1) begin bad++;
      $display("FAIL abort_flush got=%b exp=1", sa_flush_o); end
    total++; if (ready_o !== 1'b0 || sa_valid_o !== 1'b0) begin bad++;
      $display("FAIL abort_hs got=%b/%b exp=0/0", ready_o, sa_valid_o); end
    step;
    abort_i = 0; valid_i = 0;
    #1;
    total++; if (busy_o !== 1'b0 || error_o !== 1'b0 || sa_flush_o !== 1'b0) begin bad++;
      $display("FAIL abort_idle got=%b%b%b exp=000", busy_o, error_o, sa_flush_o); end
    abort_i = 1;
    #1;
    total++; if (sa_flush_o !== 1'b0) begin bad++;
      $display("FAIL abort_in_idle got=%b exp=0", sa_flush_o); end
    abort_i = 0;
    feed(8, -1, 0, acc, cyc);
    total++; if (acc !== 8) begin bad++;
      $display("FAIL abort_rejob got=%0d exp=8", acc); end
    check_flush;
    drain(1'b0);
  endtask

  task automatic test_timeout;
    int acc, cyc;
    feed(8, -1, 0, acc, cyc);
    check_flush;
    sa_valid_i = 0;
    for (int k = 0; k < 15; k++) begin
      #1;
      total++; if (sa_flush_o !== 1'b0 || busy_o !== 1'b1 || error_o !== 1'b0) begin bad++;
        $display("FAIL wd_wait k=%0d got=%b%b%b exp=010",
                 k, sa_flush_o, busy_o, error_o); end
      step;
    end
    #1;
    total++; if (sa_flush_o !== 1'b1) begin bad++;
      $display("FAIL wd_flush got=%b exp=1", sa_flush_o); end
    step;
    total++; if (busy_o !== 1'b0 || error_o !== 1'b1) begin bad++;
      $display("FAIL wd_error got=%b/%b exp=0/1", busy_o, error_o); end
    valid_i = 1; data_i = 8'h55; sa_ready_i = 1;
    #1;
    total++; if (ready_o !== 1'b1 || error_o !== 1'b1) begin bad++;
      $display("FAIL wd_hold got=%b/%b exp=1/1", ready_o, error_o); end
    step;
    valid_i = 0;
    #1;
    total++; if (error_o !== 1'b0 || busy_o !== 1'b1) begin bad++;
      $display("FAIL wd_clear got=%b/%b exp=0/1", error_o, busy_o); end
    apply_reset;
  endtask

  task automatic test_reset_mid;
    int acc, cyc, f0;
    feed(8, -1, 0, acc, cyc);
    check_flush;
    sa_valid_i = 1; sa_data_i = 8'h1A; yumi_i = 0;
    #1;
    total++; if (valid_o !== 1'b1) begin bad++;
      $display("FAIL rmid_pre got=%b exp=1", valid_o); end
    f0 = flush_cnt;
    reset_i = 1;
    step;
    #1;
    total++; if (busy_o !== 1'b0 || valid_o !== 1'b0 || data_o !== 8'h00) begin bad++;
      $display("FAIL rmid_out got=%b/%b/%h exp=0/0/00", busy_o, valid_o, data_o); end
    total++; if (sa_flush_o !== 1'b0 || error_o !== 1'b0 || sa_yumi_o !== 1'b0) begin bad++;
      $display("FAIL rmid_ctl got=%b%b%b exp=000", sa_flush_o, error_o, sa_yumi_o); end
    total++; if (flush_cnt !== f0) begin bad++;
      $display("FAIL rmid_noflush got=%0d exp=%0d", flush_cnt, f0); end
    reset_i = 0; sa_valid_i = 0;
    step;
  endtask

  initial begin
    test_reset;
    test_basic_job;
    test_drain_stall;
    test_backpressure;
    test_abort;
    test_timeout;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
